regs_wr_sched: RTL

Write scheduler for the 8080 register file. Accepts register writes from four independent requesters (ALU, load unit, incrementer, stack unit) over valid/ready channels. Each accepted write is buffered, same-address conflicts are resolved with rotating priority, and the winners are packed onto the register file's four write ports behind its single shared write enable. It also exports a pending-write mask so the decoder can stall reads of registers with writes in flight.

---
 rtl/regs_wr_sched_if.sv | 35 +++
 rtl/regs_wr_sched.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/regs_wr_sched_if.sv
// Request channel bundle for regs_wr_sched: four valid/ready write requesters
// sharing one interface instance.
interface regs_wr_sched_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic [3:0]    req_valid_i;
  logic [3:0]    req_ready_o;
  logic [AW-1:0] req_addr0_i;
  logic [AW-1:0] req_addr1_i;
  logic [AW-1:0] req_addr2_i;
  logic [AW-1:0] req_addr3_i;
  logic [DW-1:0] req_data0_i;
  logic [DW-1:0] req_data1_i;
  logic [DW-1:0] req_data2_i;
  logic [DW-1:0] req_data3_i;

  modport master (
    output req_valid_i,
    output req_addr0_i, req_addr1_i,
    output req_addr2_i, req_addr3_i,
    output req_data0_i, req_data1_i,
    output req_data2_i, req_data3_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_addr0_i, req_addr1_i,
    input  req_addr2_i, req_addr3_i,
    input  req_data0_i, req_data1_i,
    input  req_data2_i, req_data3_i,
    output req_ready_o
  );
endinterface

// File: rtl/regs_wr_sched.sv
// 8080 register-file write scheduler: 4 holding slots, rotating same-address
// arbitration, packed 4-port write. REGS_WR_SCHED_FIXED_PRIO_EN: fixed priority.
module regs_wr_sched #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  regs_wr_sched_if.slave   req,
  output logic             rf_wen_o,
  output logic [AW-1:0]    rf_waddr0_o,
  output logic [AW-1:0]    rf_waddr1_o,
  output logic [AW-1:0]    rf_waddr2_o,
  output logic [AW-1:0]    rf_waddr3_o,
  output logic [DW-1:0]    rf_wdata0_o,
  output logic [DW-1:0]    rf_wdata1_o,
  output logic [DW-1:0]    rf_wdata2_o,
  output logic [DW-1:0]    rf_wdata3_o,
  output logic [2**AW-1:0] pend_mask_o,
  output logic             busy_o
);

  logic [3:0]    hold_v;
  logic [AW-1:0] hold_a [4];
  logic [DW-1:0] hold_d [4];
  logic [AW-1:0] in_a [4];
  logic [DW-1:0] in_d [4];
  logic [AW-1:0] port_a [4];
  logic [DW-1:0] port_d [4];
  logic [AW-1:0] nxt_a [4];
  logic [DW-1:0] nxt_d [4];
  logic [1:0]    rk [4];
  logic [3:0]    grant;
  logic [3:0]    ready;
  logic [3:0]    fire;
  logic [1:0]    lo;
  logic [1:0]    rr_ptr;
  logic          deny;

  assign in_a[0] = req.req_addr0_i;
  assign in_a[1] = req.req_addr1_i;
  assign in_a[2] = req.req_addr2_i;
  assign in_a[3] = req.req_addr3_i;
  assign in_d[0] = req.req_data0_i;
  assign in_d[1] = req.req_data1_i;
  assign in_d[2] = req.req_data2_i;
  assign in_d[3] = req.req_data3_i;

`ifdef REGS_WR_SCHED_FIXED_PRIO_EN
  assign rr_ptr = 2'd0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd0;
    end else if (deny) begin
      rr_ptr <= rr_ptr + 2'd1;
    end
  end
`endif

  // rank 0 is the highest priority this cycle
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rk[i] = 2'(i) - rr_ptr;
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < 4; i++) begin
      grant[i] = hold_v[i];
      for (int j = 0; j < 4; j++) begin
        if (j != i && hold_v[j] &&
            hold_a[j] == hold_a[i] &&
            rk[j] < rk[i]) begin
          grant[i] = 1'b0;
        end
      end
    end
  end

  assign deny  = |(hold_v & ~grant);
  assign ready = ~hold_v | grant;
  assign fire  = req.req_valid_i & ready;
  assign req.req_ready_o = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v <= '0;
      for (int i = 0; i < 4; i++) begin
        hold_a[i] <= '0;
        hold_d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (fire[i]) begin
          hold_v[i] <= 1'b1;
          hold_a[i] <= in_a[i];
          hold_d[i] <= in_d[i];
        end else if (grant[i]) begin
          hold_v[i] <= 1'b0;
        end
      end
    end
  end

  // idle ports mirror the lowest granted write so duplicates are harmless
  always_comb begin
    lo = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (grant[i]) lo = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      nxt_a[i] = grant[i] ? hold_a[i] : hold_a[lo];
      nxt_d[i] = grant[i] ? hold_d[i] : hold_d[lo];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_o <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        port_a[i] <= '0;
        port_d[i] <= '0;
      end
    end else begin
      rf_wen_o <= |grant;
      if (|grant) begin
        for (int i = 0; i < 4; i++) begin
          port_a[i] <= nxt_a[i];
          port_d[i] <= nxt_d[i];
        end
      end
    end
  end

  assign rf_waddr0_o = port_a[0];
  assign rf_waddr1_o = port_a[1];
  assign rf_waddr2_o = port_a[2];
  assign rf_waddr3_o = port_a[3];
  assign rf_wdata0_o = port_d[0];
  assign rf_wdata1_o = port_d[1];
  assign rf_wdata2_o = port_d[2];
  assign rf_wdata3_o = port_d[3];

  always_comb begin
    pend_mask_o = '0;
    for (int i = 0; i < 4; i++) begin
      if (hold_v[i]) pend_mask_o[hold_a[i]] = 1'b1;
      if (rf_wen_o)  pend_mask_o[port_a[i]] = 1'b1;
    end
  end

  assign busy_o = |hold_v | rf_wen_o;

endmodule
